// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause field positions.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;
    localparam int CAUSE_BD  = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: raises flush/redirect from the M stage and
// holds SR, Cause and EPC for mfc0/mtc0/eret.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE = 32'h2037_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a_sel,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_m,
    input  logic        eret_m,
    input  logic [5:0]  hwint,
    output logic [31:0] rdata,
    output logic        exc_req,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_out
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        ex_req;
    logic [31:0] pc_aligned;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req    = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
    assign ex_req     = (exccode_m != EXC_INT) & ~sr_exl;
    assign exc_req    = (int_req | ex_req) & ~eret_m;
    assign exc_pc     = EXC_VECTOR;
    assign pc_aligned = {pc_m[31:2], 2'b00};
    assign epc_out    = (we && a_sel == CP0_EPC) ? wdata : epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hwint;
            if (exc_req) begin
                // Exception entry overrides any same-cycle mtc0
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_INT : exccode_m;
                cause_bd  <= bd_m;
                epc       <= bd_m ? pc_aligned - 32'd4 : pc_aligned;
            end else begin
                if (we && a_sel == CP0_SR) begin
                    sr_im  <= wdata[SR_IM_HI:SR_IM_LO];
                    sr_exl <= wdata[SR_EXL];
                    sr_ie  <= wdata[SR_IE];
                end
                if (we && a_sel == CP0_EPC)
                    epc <= wdata;
                // Placed after the SR write so eret's EXL clear wins
                if (eret_m)
                    sr_exl <= 1'b0;
            end
        end
    end

    assign sr_val    = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'h0, cause_ip, 3'b000, cause_exc, 2'b00};

    always_comb begin
        rdata = '0;
        case (a_sel)
            CP0_SR:    rdata = sr_val;
            CP0_CAUSE: rdata = cause_val;
            CP0_EPC:   rdata = epc;
            CP0_PRID:  rdata = PRID_VALUE;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: expectations queued at drive time, popped at sample time.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a_sel;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic        eret_m;
    logic [5:0]  hwint;
    logic [31:0] rdata;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic [31:0] epc_out;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .a_sel(a_sel), .wdata(wdata), .we(we),
        .pc_m(pc_m), .bd_m(bd_m), .exccode_m(exccode_m), .eret_m(eret_m),
        .hwint(hwint), .rdata(rdata), .exc_req(exc_req), .exc_pc(exc_pc),
        .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic push(input string n, input logic [31:0] v);
        exp_t x;
        x.name = n;
        x.val  = v;
        sb.push_back(x);
    endtask

    task automatic idle();
        we = 1'b0; wdata = '0; eret_m = 1'b0; exccode_m = '0; bd_m = 1'b0; pc_m = '0;
    endtask

    // Moves to the next negedge with quiet control inputs and the given read select.
    task automatic cyc(input logic [4:0] sel);
        @(negedge clk);
        idle();
        a_sel = sel;
    endtask

    task automatic chk_rd();
        e = sb.pop_front();
        n_chk++;
        if (rdata !== e.val) begin
            n_fail++;
            $display("FAIL %s: rdata=%h expected %h", e.name, rdata, e.val);
        end
    endtask

    task automatic chk_req();
        e = sb.pop_front();
        n_chk++;
        if ({31'b0, exc_req} !== e.val) begin
            n_fail++;
            $display("FAIL %s: exc_req=%b expected %0d", e.name, exc_req, e.val);
        end
    endtask

    task automatic chk_epc();
        e = sb.pop_front();
        n_chk++;
        if (epc_out !== e.val) begin
            n_fail++;
            $display("FAIL %s: epc_out=%h expected %h", e.name, epc_out, e.val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hwint = '0; a_sel = '0; idle();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int i = 12; i <= 15; i++) begin
            a_sel = 5'(i);
            push($sformatf("reset_reg%0d", i), (i == 15) ? 32'h2037_0000 : 32'h0);
            #1 chk_rd();
        end
        push("reset_exc_req", 0);
        chk_req();
        push("reset_epc_out", 0);
        chk_epc();
        a_sel = 5'd20;
        push("unmapped_read", 0);
        #1 chk_rd();
    endtask

    task automatic test_adel();
        cyc(5'd13);
        exccode_m = 5'd4; pc_m = 32'h0000_3008;
        push("adel_req", 1);
        #1 chk_req();
        n_chk++;
        if (exc_pc !== 32'h0000_4180) begin
            n_fail++;
            $display("FAIL adel_exc_pc: exc_pc=%h expected 00004180", exc_pc);
        end
        @(negedge clk);
        push("adel_masked_by_exl", 0);
        #1 chk_req();
        a_sel = 5'd14; push("adel_epc", 32'h3008);   #1 chk_rd();
        a_sel = 5'd13; push("adel_cause", 32'h10);   #1 chk_rd();
        a_sel = 5'd12; push("adel_sr_exl", 32'h2);   #1 chk_rd();
        cyc(5'd12); we = 1'b1; wdata = 32'h0;
    endtask

    task automatic test_bd();
        cyc(5'd14);
        exccode_m = 5'd12; pc_m = 32'h0000_3010; bd_m = 1'b1;
        cyc(5'd14); push("bd_epc", 32'h300C);        #1 chk_rd();
        a_sel = 5'd13; push("bd_cause", 32'h8000_0030); #1 chk_rd();
        cyc(5'd12); we = 1'b1; wdata = 32'h0;
    endtask

    task automatic test_interrupt();
        cyc(5'd12); we = 1'b1; wdata = 32'h0000_0401;
        cyc(5'd12); push("int_sr", 32'h401); #1 chk_rd();
        hwint = 6'b000001; pc_m = 32'h3044;
        push("int_req", 1); #1 chk_req();
        cyc(5'd13); push("int_cause", 32'h400); #1 chk_rd();
        a_sel = 5'd14; push("int_epc", 32'h3044); #1 chk_rd();
        hwint = '0; we = 1'b1; a_sel = 5'd12; wdata = 32'h0000_0401;
        cyc(5'd12); hwint = 6'b000010;
        push("int_masked_line", 0); #1 chk_req();
        hwint = 6'b000001; exccode_m = 5'd10;
        push("int_with_ri_req", 1); #1 chk_req();
        cyc(5'd13); push("int_over_ri_cause", 32'h400); #1 chk_rd();
    endtask

    task automatic test_eret();
        // EXL still set from the interrupt, hwint still pending
        cyc(5'd14); we = 1'b1; wdata = 32'h3020;
        cyc(5'd14); eret_m = 1'b1;
        push("eret_epc_out", 32'h3020); #1 chk_epc();
        push("eret_masks_req", 0); chk_req();
        cyc(5'd12); pc_m = 32'h3023;
        push("eret_sr_exl_clear", 32'h401); #1 chk_rd();
        push("eret_then_int_req", 1); chk_req();
        cyc(5'd14); push("epc_aligned", 32'h3020); #1 chk_rd();
        hwint = '0; eret_m = 1'b1; we = 1'b1; a_sel = 5'd12; wdata = 32'h0000_0403;
        cyc(5'd12); push("eret_vs_mtc0_sr", 32'h401); #1 chk_rd();
    endtask

    task automatic test_conflict();
        cyc(5'd14); we = 1'b1; wdata = 32'h3100;
        push("fwd_epc_out", 32'h3100); #1 chk_epc();
        push("rdata_no_fwd", 32'h3020); chk_rd();
        cyc(5'd14); we = 1'b1; wdata = 32'hFFFF_FFFF; a_sel = 5'd13;
        cyc(5'd13); push("cause_write_ignored", 32'h0); #1 chk_rd();
        a_sel = 5'd14; push("epc_written", 32'h3100); #1 chk_rd();
        we = 1'b1; wdata = 32'h3100; exccode_m = 5'd5; pc_m = 32'h3040;
        push("drop_req", 1); #1 chk_req();
        cyc(5'd14); push("dropped_write_epc", 32'h3040); #1 chk_rd();
        push("dropped_write_epc_out", 32'h3040); chk_epc();
        a_sel = 5'd13; push("ades_cause", 32'h14); #1 chk_rd();
    endtask

    task automatic test_back_to_back();
        // Clear EXL, then two faults on consecutive cycles: only the first is taken.
        cyc(5'd12); we = 1'b1; wdata = 32'h0;
        cyc(5'd14); exccode_m = 5'd4; pc_m = 32'h5000;
        push("b2b_first_req", 1); #1 chk_req();
        cyc(5'd14); exccode_m = 5'd12; pc_m = 32'h5004;
        push("b2b_second_masked", 0); #1 chk_req();
        cyc(5'd14); push("b2b_epc_first", 32'h5000); #1 chk_rd();
        a_sel = 5'd13; push("b2b_cause_first", 32'h10); #1 chk_rd();
    endtask

    initial begin
        test_reset();
        test_adel();
        test_bd();
        test_interrupt();
        test_eret();
        test_conflict();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
